// File: rtl/alu_operand_pkg.sv
// Shared definitions for the ALU operand stage: immediate conditioning
// modes and the helper that derives the select width.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT     = 2'b00,
    MODE_ZEXT     = 2'b01,
    MODE_SEXT_SL2 = 2'b10,
    MODE_LUI      = 2'b11
  } imm_mode_e;

  // Number of words the output buffer can hold.
  localparam int BUF_DEPTH = 2;

  // Select width: one code per word source, one for the immediate,
  // one for the constant.
  function automatic int sel_w_f(input int num_src);
    return $clog2(num_src + 2);
  endfunction

endpackage

// File: rtl/operand_skid_buf.sv
// Two-entry valid/ready buffer. The head entry drives the outputs
// directly from flops; ready is a registered copy of "not full", so
// there is no combinational path from the consumer's ready back to the
// producer.
module operand_skid_buf
  import alu_operand_pkg::*;
#(
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  localparam logic [1:0] CNT_FULL = 2'(BUF_DEPTH);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          ready_q, ready_d;
  logic          push_s;
  logic          pop_s;

  assign push_s      = in_valid_i && ready_q;
  assign pop_s       = (count_q != 2'd0) && out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = in_data_i;
          count_d = 2'd1;
        end else begin
          tail_d  = in_data_i;
          count_d = CNT_FULL;
        end
      end
      2'b01: begin
        if (count_q == CNT_FULL) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end else begin
          // Head keeps its value so the output holds the last word.
          count_d = 2'd0;
        end
      end
      2'b11: begin
        // Push needs count<2, pop needs count>0: only count==1 lands here,
        // and the departing head is replaced by the arriving word.
        head_d  = in_data_i;
        count_d = 2'd1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    ready_d = (count_d != CNT_FULL);
  end

  // Buffer state; ready is held low while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand selector for the ALU B input: chooses a register
// word, a conditioned immediate or a constant, and hands the result plus
// the select code through a two-entry valid/ready buffer.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 3,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4,
  parameter int SEL_W     = sel_w_f(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [IMM_W-1:0]         imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_tag,
  output logic                     err_sel,
  input  logic                     clr_err
);

  localparam int               DW         = WIDTH + SEL_W;
  localparam logic [SEL_W-1:0] SEL_IMM    = SEL_W'(NUM_SRC);
  localparam logic [SEL_W-1:0] SEL_CONST  = SEL_W'(NUM_SRC + 1);
  localparam logic [WIDTH-1:0] CONST_WORD = WIDTH'(CONST_VAL);

  logic [WIDTH-1:0] imm_sext_s;
  logic [WIDTH-1:0] imm_zext_s;
  logic [WIDTH-1:0] imm_cond_s;
  logic [WIDTH-1:0] src_word_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_bad_s;
  logic             push_s;
  logic [DW-1:0]    buf_out_s;
  logic             err_q, err_d;

  assign imm_sext_s = {{(WIDTH - IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext_s = {{(WIDTH - IMM_W){1'b0}}, imm};

  // Immediate conditioning according to mode.
  always_comb begin
    imm_cond_s = imm_zext_s;
    case (imm_mode_e'(mode))
      MODE_SEXT:     imm_cond_s = imm_sext_s;
      MODE_ZEXT:     imm_cond_s = imm_zext_s;
      MODE_SEXT_SL2: imm_cond_s = imm_sext_s << 2;
      MODE_LUI:      imm_cond_s = imm_zext_s << 16;
      default:       imm_cond_s = imm_zext_s;
    endcase
  end

  // Register-word mux over the flattened source bus.
  always_comb begin
    src_word_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_word_s = (sel == SEL_W'(i)) ? src_flat[i*WIDTH +: WIDTH] : src_word_s;
    end
  end

  // Final operand select; codes past the constant yield zero and flag an error.
  always_comb begin
    sel_data_s = '0;
    sel_bad_s  = 1'b0;
    if (sel < SEL_IMM) begin
      sel_data_s = src_word_s;
    end else if (sel == SEL_IMM) begin
      sel_data_s = imm_cond_s;
    end else if (sel == SEL_CONST) begin
      sel_data_s = CONST_WORD;
    end else begin
      sel_data_s = '0;
      sel_bad_s  = 1'b1;
    end
  end

  assign push_s = in_valid && in_ready;

  // Sticky error: setting wins over a simultaneous clear.
  always_comb begin
    if (push_s && sel_bad_s) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sel = err_q;

  operand_skid_buf #(
    .DW (DW)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({sel, sel_data_s}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (buf_out_s)
  );

  assign out_tag  = buf_out_s[DW-1:WIDTH];
  assign out_data = buf_out_s[WIDTH-1:0];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a queue-based reference model is advanced
// on every clock edge and compared against the DUT on every falling edge,
// alongside directed literal checks.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  sel = 3'd0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] src_w [3];
  logic [95:0] src_flat;
  logic [15:0] imm = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_tag;
  logic        err_sel;
  logic        clr_err = 1'b0;

  int checks = 0;
  int errors = 0;

  assign src_flat = {src_w[2], src_w[1], src_w[0]};

  alu_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .src_flat  (src_flat),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .err_sel   (err_sel),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand computed with plain integer arithmetic.
  function automatic logic [31:0] ref_data(input int s, input int m,
                                           input logic [95:0] flat, input int im);
    longint v;
    longint sx;
    sx = (im >= 32768) ? longint'(im) - 65536 : longint'(im);
    if (s < 3) return flat[s*32 +: 32];
    if (s == 4) return 32'd4;
    if (s > 4) return 32'd0;
    case (m)
      0:       v = sx;
      1:       v = longint'(im);
      2:       v = sx * 4;
      default: v = longint'(im) * 65536;
    endcase
    return v[31:0];
  endfunction

  // Model state: buffered {tag,data} words in arrival order.
  logic [34:0] q[$];
  logic [34:0] shown = '0;
  bit          m_err = 1'b0;
  bit          m_ok = 1'b0;
  bit          m_push;
  bit          m_pop;
  int          pops = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q.delete();
        shown = '0;
        m_err = 1'b0;
        m_ok  = 1'b0;
      end else begin
        m_push = m_ok && (q.size() < 2) && in_valid;
        m_pop  = (q.size() > 0) && out_ready;
        if (m_pop) begin
          void'(q.pop_front());
          pops++;
        end
        if (m_push) q.push_back({sel, ref_data(int'(sel), int'(mode), src_flat, int'(imm))});
        if (m_push && sel > 3'd4) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        if (q.size() > 0) shown = q[0];
        m_ok = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("cmp_data",  64'(out_data),  64'(shown[31:0]));
      chk("cmp_tag",   64'(out_tag),   64'(shown[34:32]));
      chk("cmp_ready", 64'(in_ready),  64'(m_ok && (q.size() < 2) && reset));
      chk("cmp_err",   64'(err_sel),   64'(m_err));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic new_req();
    sel      = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) sel = 3'($urandom_range(0, 4));
    mode     = 2'($urandom_range(0, 3));
    imm      = 16'($urandom);
    src_w[0] = $urandom;
    src_w[1] = $urandom;
    src_w[2] = $urandom;
    clr_err  = ($urandom_range(0, 9) == 0);
  endtask

  int sent;
  int cyc;
  int pops0;
  bit acc;

  initial begin
    src_w[0] = 32'd0;
    src_w[1] = 32'd0;
    src_w[2] = 32'd0;

    // Model pinned against hand-computed immediates.
    chk("pin_sext", 64'(ref_data(3, 0, 96'd0, 32'h8001)), 64'h0000_0000_FFFF_8001);
    chk("pin_zext", 64'(ref_data(3, 1, 96'd0, 32'h8001)), 64'h0000_0000_0000_8001);
    chk("pin_sl2",  64'(ref_data(3, 2, 96'd0, 32'h8001)), 64'h0000_0000_FFFE_0004);
    chk("pin_lui",  64'(ref_data(3, 3, 96'd0, 32'h8001)), 64'h0000_0000_8001_0000);

    // Reset state.
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_ready", 64'(in_ready),  64'd0);
    reset = 1'b1;
    step();
    chk("rel_ready", 64'(in_ready), 64'd1);

    // Register source and constant.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 3'd1;
    src_w[1]  = 32'hDEADBEEF;
    step();
    chk("src1_data", 64'(out_data), 64'hDEADBEEF);
    chk("src1_tag",  64'(out_tag),  64'd1);
    sel = 3'd4;
    step();
    chk("const_data", 64'(out_data), 64'd4);

    // Immediate modes.
    sel = 3'd3;
    imm = 16'h8001;
    mode = 2'd0; step(); chk("imm_m00", 64'(out_data), 64'hFFFF8001);
    mode = 2'd1; step(); chk("imm_m01", 64'(out_data), 64'h00008001);
    mode = 2'd2; step(); chk("imm_m10", 64'(out_data), 64'hFFFE0004);
    mode = 2'd3; step(); chk("imm_m11", 64'(out_data), 64'h80010000);
    in_valid = 1'b0;
    step();

    // Stall with two words, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 3'd0; src_w[0] = 32'hAAAA0001; step();
    sel = 3'd2; src_w[2] = 32'hBBBB0002; step();
    in_valid = 1'b0;
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("stall_a",    64'(out_data), 64'hAAAA0001);
    step(); step();
    chk("stall_a_hold", 64'(out_data), 64'hAAAA0001);
    out_ready = 1'b1;
    step();
    chk("drain_b",  64'(out_data),  64'hBBBB0002);
    chk("drain_bv", 64'(out_valid), 64'd1);
    step();
    chk("empty_v",    64'(out_valid), 64'd0);
    chk("empty_hold", 64'(out_data),  64'hBBBB0002);

    // Sticky out-of-range select error.
    in_valid = 1'b1; sel = 3'd7; step();
    chk("bad_data", 64'(out_data), 64'd0);
    chk("bad_err",  64'(err_sel),  64'd1);
    in_valid = 1'b0; step();
    chk("err_sticky", 64'(err_sel), 64'd1);
    in_valid = 1'b1; clr_err = 1'b1; step();
    chk("err_set_wins", 64'(err_sel), 64'd1);
    in_valid = 1'b0; step();
    chk("err_cleared", 64'(err_sel), 64'd0);
    clr_err = 1'b0;
    step();

    // Reset while the buffer is full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 3'd0; step();
    sel = 3'd7; step();
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_err",   64'(err_sel),   64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Full-rate random stream.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pops0 = pops;
    sent  = 0;
    cyc   = 0;
    new_req();
    while (sent < 100 && cyc < 400) begin
      acc = in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        new_req();
      end
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
    chk("stream_sent",   64'(sent), 64'd100);
    chk("stream_cycles", 64'(cyc),  64'd100);
    repeat (3) step();
    chk("stream_outputs", 64'(pops - pops0), 64'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
